// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one operation at a time to a combinational ALU and writes r / R15 back.
// Optional build macro OVF_TRAP_EN: an overflowing capture suppresses write-back and pulses ovf_trap.
module alu_op_sequencer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned R15_ADDR   = 15,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [SEL_W-1:0]  req_sel,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [ADDR_W-1:0] req_rd,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_r,
  input  logic [DATA_W-1:0] alu_r15,
  input  logic              alu_ovf,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              ovf_flag,
  input  logic              ovf_clr,
  output logic              ill_op,
`ifdef OVF_TRAP_EN
  output logic              ovf_trap,
`endif
  output logic [15:0]       op_count
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned OPC_W = 16;

  typedef enum logic [1:0] {IDLE, EXEC, WB_R, WB_HI} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W-1:0] rd_q, rd_n;
  logic [DATA_W-1:0] hi_q, hi_n;
  logic [DATA_W-1:0] alu_a_n, alu_b_n, wb_data_n;
  logic [SEL_W-1:0]  alu_sel_n;
  logic [ADDR_W-1:0] wb_addr_n;
  logic [OPC_W-1:0]  op_count_n;
  logic              req_ready_n, wb_valid_n, ovf_flag_n, ill_op_n;
  logic              sel_ill, op_wide;
`ifdef OVF_TRAP_EN
  logic              trap_n;
`endif

  assign sel_ill = (req_sel >= SEL_W'(6));
  assign op_wide = (alu_sel == SEL_W'(4)) || (alu_sel == SEL_W'(5));

  // Next-state and next-output logic
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rd_n       = rd_q;
    hi_n       = hi_q;
    alu_a_n    = alu_a;
    alu_b_n    = alu_b;
    alu_sel_n  = alu_sel;
    wb_addr_n  = wb_addr;
    wb_data_n  = wb_data;
    op_count_n = op_count;
    ill_op_n   = 1'b0;
    ovf_flag_n = ovf_clr ? 1'b0 : ovf_flag;
`ifdef OVF_TRAP_EN
    trap_n     = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          if (sel_ill) begin
            ill_op_n = 1'b1;
          end else begin
            alu_a_n   = req_a;
            alu_b_n   = req_b;
            alu_sel_n = req_sel;
            rd_n      = req_rd;
            cnt_n     = CNT_W'(SETTLE_CYC - 1);
            state_n   = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          hi_n      = alu_r15;
          wb_data_n = alu_r;
          wb_addr_n = rd_q;
          if (alu_ovf) ovf_flag_n = 1'b1;
`ifdef OVF_TRAP_EN
          if (alu_ovf) begin
            trap_n  = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = WB_R;
          end
`else
          state_n = WB_R;
`endif
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      WB_R: begin
        if (wb_ready) begin
          if (op_wide) begin
            wb_addr_n = ADDR_W'(R15_ADDR);
            wb_data_n = hi_q;
            state_n   = WB_HI;
          end else begin
            op_count_n = op_count + OPC_W'(1);
            state_n    = IDLE;
          end
        end
      end
      WB_HI: begin
        if (wb_ready) begin
          op_count_n = op_count + OPC_W'(1);
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    req_ready_n = (state_n == IDLE);
    wb_valid_n  = (state_n == WB_R) || (state_n == WB_HI);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_q      <= '0;
      hi_q      <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      req_ready <= 1'b1;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      ovf_flag  <= 1'b0;
      ill_op    <= 1'b0;
      op_count  <= '0;
`ifdef OVF_TRAP_EN
      ovf_trap  <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rd_q      <= rd_n;
      hi_q      <= hi_n;
      alu_a     <= alu_a_n;
      alu_b     <= alu_b_n;
      alu_sel   <= alu_sel_n;
      req_ready <= req_ready_n;
      wb_valid  <= wb_valid_n;
      wb_addr   <= wb_addr_n;
      wb_data   <= wb_data_n;
      ovf_flag  <= ovf_flag_n;
      ill_op    <= ill_op_n;
      op_count  <= op_count_n;
`ifdef OVF_TRAP_EN
      ovf_trap  <= trap_n;
`endif
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus randomized ops against a write-list model.
module tb_alu_op_sequencer;

  localparam int unsigned SETTLE = 1;
`ifdef OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  req_sel = '0;
  logic [15:0] req_a = '0, req_b = '0;
  logic [3:0]  req_rd = '0;
  logic [15:0] alu_a, alu_b, alu_r, alu_r15;
  logic [2:0]  alu_sel;
  logic        alu_ovf;
  logic        wb_valid, wb_ready;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        ovf_flag, ovf_clr = 1'b0, ill_op;
  logic [15:0] op_count;
`ifdef OVF_TRAP_EN
  logic        ovf_trap;
`endif

  alu_op_sequencer #(.SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_r(alu_r), .alu_r15(alu_r15), .alu_ovf(alu_ovf),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .ovf_flag(ovf_flag), .ovf_clr(ovf_clr), .ill_op(ill_op),
`ifdef OVF_TRAP_EN
    .ovf_trap(ovf_trap),
`endif
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // ALU stub: r = a+b, R15 = a^b, ovf = carry out
  always_comb begin
    {alu_ovf, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
    alu_r15 = alu_a ^ alu_b;
  end

  int errors = 0, checks = 0;
  int wb_mode = 0;  // 0: ready high, 1: random, 2: ready low

  // Register-file side: back-pressure driver
  initial begin
    wb_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (wb_mode)
        0:       wb_ready = 1'b1;
        1:       wb_ready = 1'($urandom_range(0, 1));
        default: wb_ready = 1'b0;
      endcase
    end
  end

  // Write log plus hold-stability tracking while wb_valid waits for wb_ready
  logic [3:0]  wa [0:1023];
  logic [15:0] wd [0:1023];
  int          wr_cnt = 0, stab_n = 0, stab_bad = 0;
  logic        have_prev = 1'b0, pv, pr;
  logic [3:0]  pa;
  logic [15:0] pd;

  always @(negedge clk) begin
    if (rst) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev && pv && !pr) begin
        stab_n++;
        if (!(wb_valid === 1'b1 && wb_addr === pa && wb_data === pd)) stab_bad++;
      end
      if (wb_valid && wb_ready && wr_cnt < 1024) begin
        wa[wr_cnt] = wb_addr;
        wd[wr_cnt] = wb_data;
        wr_cnt++;
      end
      pv = wb_valid; pr = wb_ready; pa = wb_addr; pd = wb_data;
      have_prev = 1'b1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model state: expected writes of the current op, count and sticky flag
  int          rd_idx = 0;
  int          en = 0;
  logic [3:0]  ea [2];
  logic [15:0] ed [2];
  logic [15:0] exp_count = '0;
  logic        exp_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (req_ready !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_idle"}, 32'(req_ready), 32'(1));
  endtask

  task automatic do_reset(input bit full);
    rst = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'(1));
    chk("rst_wb_valid", 32'(wb_valid), 32'(0));
    chk("rst_op_count", 32'(op_count), 32'(0));
    chk("rst_ovf_flag", 32'(ovf_flag), 32'(0));
    chk("rst_ill_op", 32'(ill_op), 32'(0));
    if (full) begin
      chk("rst_alu_a", 32'(alu_a), 32'(0));
      chk("rst_wb_data", 32'(wb_data), 32'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    exp_count = '0;
    exp_ovf   = 1'b0;
    rd_idx    = wr_cnt;
  endtask

  // Present one request (caller ensures idle), build the expected write list
  task automatic issue(input logic [2:0] sel, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] rd);
    logic [16:0] sum;
    logic        legal;
    req_valid = 1'b1; req_sel = sel; req_a = a; req_b = b; req_rd = rd;
    step();
    req_valid = 1'b0;
    sum   = {1'b0, a} + {1'b0, b};
    legal = (sel < 3'd6);
    en    = 0;
    if (legal) begin
      if (sum[16]) exp_ovf = 1'b1;
      if (!(TRAP && sum[16])) begin
        ea[0] = rd; ed[0] = sum[15:0]; en = 1;
        if (sel == 3'd4 || sel == 3'd5) begin
          ea[1] = 4'hF; ed[1] = a ^ b; en = 2;
        end
        exp_count = exp_count + 16'd1;
      end
    end
    chk("ill_op", 32'(ill_op), 32'(!legal));
    if (legal) begin
      chk("alu_a", 32'(alu_a), 32'(a));
      chk("alu_b", 32'(alu_b), 32'(b));
      chk("alu_sel", 32'(alu_sel), 32'(sel));
      chk("busy", 32'(req_ready), 32'(0));
    end else begin
      chk("ill_ready", 32'(req_ready), 32'(1));
    end
  endtask

  task automatic finish_op(input string tag);
    wait_idle(tag);
    chk({tag, "_nwr"}, 32'(wr_cnt - rd_idx), 32'(en));
    for (int i = 0; i < en; i++) begin
      if (rd_idx + i < wr_cnt) begin
        chk({tag, "_addr"}, 32'(wa[rd_idx+i]), 32'(ea[i]));
        chk({tag, "_data"}, 32'(wd[rd_idx+i]), 32'(ed[i]));
      end
    end
    rd_idx = wr_cnt;
    chk({tag, "_count"}, 32'(op_count), 32'(exp_count));
    chk({tag, "_ovf"}, 32'(ovf_flag), 32'(exp_ovf));
  endtask

  initial begin
    int n;
    logic [2:0]  rs;
    logic [15:0] ra, rb;

    // Reset values
    repeat (2) @(negedge clk);
    do_reset(1'b1);

    // T1: simple add, accept-to-write timing
    issue(3'd0, 16'h0001, 16'h0002, 4'd3);
    for (int i = 1; i < int'(SETTLE); i++) begin
      step();
      chk("t1_settle_novalid", 32'(wb_valid), 32'(0));
    end
    step();
    chk("t1_wb_valid", 32'(wb_valid), 32'(1));
    chk("t1_wb_addr", 32'(wb_addr), 32'(3));
    chk("t1_wb_data", 32'(wb_data), 32'(16'h0003));
    chk("t1_ready_low", 32'(req_ready), 32'(0));
    step();
    chk("t1_ready_back", 32'(req_ready), 32'(1));
    chk("t1_valid_drop", 32'(wb_valid), 32'(0));
    finish_op("t1");

    // T2: wide op with carry out, from a fresh count
    do_reset(1'b0);
    issue(3'd4, 16'hCCCC, 16'hCCCC, 4'd2);
    finish_op("t2");

    // T3: back-pressure hold in WB_R
    wb_mode = 2;
    step();
    issue(3'd0, 16'h0005, 16'h0006, 4'd1);
    n = 0;
    while (wb_valid !== 1'b1 && n < 50) begin step(); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 32'(wb_valid), 32'(1));
      chk("t3_hold_addr", 32'(wb_addr), 32'(1));
      chk("t3_hold_data", 32'(wb_data), 32'(16'h000B));
      chk("t3_hold_ready", 32'(req_ready), 32'(0));
      step();
    end
    wb_mode = 0;
    finish_op("t3");

    // T4: illegal select
    issue(3'd7, 16'h1111, 16'h2222, 4'd4);
    step();
    chk("t4_ill_once", 32'(ill_op), 32'(0));
    chk("t4_no_valid", 32'(wb_valid), 32'(0));
    finish_op("t4");

    // T5a: reset in EXEC
    issue(3'd0, 16'h0100, 16'h0200, 4'd5);
    do_reset(1'b0);
    repeat (4) step();
    chk("t5a_no_write", 32'(wr_cnt - rd_idx), 32'(0));
    chk("t5a_no_valid", 32'(wb_valid), 32'(0));

    // T5b: reset in WB_HI drops the second write
    issue(3'd4, 16'h0010, 16'h0020, 4'd6);
    n = 0;
    while (!(wb_valid === 1'b1 && wb_addr === 4'hF) && n < 50) begin step(); n++; end
    chk("t5b_reached_hi", 32'(wb_addr), 32'(15));
    chk("t5b_first_write", 32'(wr_cnt - rd_idx), 32'(1));
    if (wr_cnt > rd_idx) chk("t5b_first_data", 32'(wd[rd_idx]), 32'(16'h0030));
    do_reset(1'b0);
    repeat (4) step();
    chk("t5b_no_second", 32'(wr_cnt - rd_idx), 32'(0));

    // rd == R15 on a wide op: both writes, R15 value last
    issue(3'd5, 16'h1234, 16'h0F0F, 4'hF);
    finish_op("r15_dst");

    // Overflow capture coinciding with ovf_clr: set wins (and trap behaviour if built in)
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    chk("clr_flag", 32'(ovf_flag), 32'(0));
    issue(3'd0, 16'hFFFF, 16'h0001, 4'd9);
    ovf_clr = 1'b1;
    repeat (SETTLE) step();
    ovf_clr = 1'b0;
    chk("set_wins", 32'(ovf_flag), 32'(1));
`ifdef OVF_TRAP_EN
    chk("trap_pulse", 32'(ovf_trap), 32'(1));
    chk("trap_no_valid", 32'(wb_valid), 32'(0));
    step();
    chk("trap_once", 32'(ovf_trap), 32'(0));
`else
    chk("ovf_written", 32'(wb_valid), 32'(1));
`endif
    finish_op("ovf");

    // Randomized ops with random back-pressure and occasional flag clears
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        exp_ovf = 1'b0;
      end
      wb_mode = int'($urandom_range(0, 1));
      rs = 3'($urandom_range(0, 7));
      ra = 16'($urandom);
      rb = 16'($urandom);
      issue(rs, ra, rb, 4'($urandom_range(0, 15)));
      finish_op("rnd");
    end
    wb_mode = 0;

    chk("wb_hold_stable", 32'(stab_bad), 32'(0));
    chk("wb_hold_seen", 32'(stab_n > 0), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
